// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: ID-stage main control with load-use stall, branch flush and
// illegal-opcode tracking.
//
// Handshake: valid_i qualifies the IF/ID instruction. While Stall_o is high the
// upstream holds PC and IF/ID (PCWrite_o low), and this block loads bubbles into
// ID/EX. Flush_i kills the ID instruction and overrides any stall that cycle.
module ctrl_pipe_unit #(
    parameter int OP_WIDTH     = 7,
    parameter int REG_AW       = 5,
    parameter int STALL_CYCLES = 1,
    parameter int EXT_EN       = 1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [OP_WIDTH-1:0]  Op_i,
    input  logic [REG_AW-1:0]    RS1addr_i,
    input  logic [REG_AW-1:0]    RS2addr_i,
    input  logic [REG_AW-1:0]    RDaddr_i,
    input  logic                 Flush_i,
    output logic [1:0]           ALUOp_o,
    output logic                 ALUSrc_o,
    output logic                 Branch_o,
    output logic                 MemRead_o,
    output logic                 MemWrite_o,
    output logic                 RegWrite_o,
    output logic                 MemtoReg_o,
    output logic                 Jump_o,
    output logic [REG_AW-1:0]    RDaddr_o,
    output logic                 Stall_o,
    output logic                 PCWrite_o,
    output logic                 Illegal_o,
    output logic [CNT_WIDTH-1:0] IllegalCnt_o,
    output logic                 DbgState_o
);

    localparam logic [OP_WIDTH-1:0] OP_R   = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] OP_I   = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] OP_LD  = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] OP_SD  = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] OP_BEQ = OP_WIDTH'(7'b1100011);
    localparam logic [OP_WIDTH-1:0] OP_LUI = OP_WIDTH'(7'b0110111);
    localparam logic [OP_WIDTH-1:0] OP_JAL = OP_WIDTH'(7'b1101111);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_STALL = 1'b1;

    // Stall counter only needs to hold STALL_CYCLES-1.
    localparam int SCW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES + 1) : 1;
    localparam logic [SCW-1:0] STALL_INIT = SCW'(STALL_CYCLES - 1);

    // Control bundle packing: {ALUOp[1:0],ALUSrc,Branch,MemRead,MemWrite,RegWrite,MemtoReg,Jump}
    logic [8:0]           r_ctrl;
    logic [REG_AW-1:0]    r_rd;
    logic [0:0]           r_state;
    logic [SCW-1:0]       r_scnt;
    logic                 r_illegal;
    logic [CNT_WIDTH-1:0] r_icnt;

    logic [8:0] w_dec;
    logic       w_legal;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_rs_match;
    logic       w_hazard;
    logic       w_stall;
    logic       w_load;
    logic       w_illegal_evt;

    // Opcode decode into the control bundle; unknown opcodes decode to all zeros.
    always_comb begin
        w_dec     = 9'b0;
        w_legal   = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (Op_i)
            OP_R: begin
                w_dec = 9'b10_0_0_0_0_1_0_0; w_legal = 1'b1;
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
            OP_I: begin
                w_dec = 9'b00_1_0_0_0_1_0_0; w_legal = 1'b1;
                w_use_rs1 = 1'b1;
            end
            OP_LD: begin
                w_dec = 9'b00_1_0_1_0_1_1_0; w_legal = 1'b1;
                w_use_rs1 = 1'b1;
            end
            OP_SD: begin
                w_dec = 9'b00_1_0_0_1_0_0_0; w_legal = 1'b1;
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
            OP_BEQ: begin
                w_dec = 9'b01_0_1_0_0_0_0_0; w_legal = 1'b1;
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
            OP_LUI: begin
                if (EXT_EN != 0) begin
                    w_dec = 9'b00_1_0_0_0_1_0_0; w_legal = 1'b1;
                end
            end
            OP_JAL: begin
                if (EXT_EN != 0) begin
                    w_dec = 9'b00_0_0_0_0_1_0_1; w_legal = 1'b1;
                end
            end
            default: begin
                w_dec   = 9'b0;
                w_legal = 1'b0;
            end
        endcase
        // Writes to x0 are architecturally discarded; suppress them here.
        if (RDaddr_i == '0) begin
            w_dec[2] = 1'b0;
        end
    end

    // Load-use hazard detection against the load currently in ID/EX.
    always_comb begin
        w_rs_match = (w_use_rs1 && (RS1addr_i == r_rd)) ||
                     (w_use_rs2 && (RS2addr_i == r_rd));
        w_hazard   = (r_state == S_RUN) && valid_i && r_ctrl[4] &&
                     (r_rd != '0) && w_rs_match;
        w_stall    = rst_i && !Flush_i && ((r_state == S_STALL) || w_hazard);
        w_load     = valid_i && w_legal && !Flush_i &&
                     (r_state == S_RUN) && !w_hazard;
        w_illegal_evt = valid_i && !w_legal && !Flush_i &&
                        (r_state == S_RUN) && !w_hazard;
    end

    // ID/EX control register: decoded bundle or bubble.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ctrl <= '0;
            r_rd   <= '0;
        end else if (w_load) begin
            r_ctrl <= w_dec;
            r_rd   <= RDaddr_i;
        end else begin
            r_ctrl <= '0;
            r_rd   <= '0;
        end
    end

    // Stall FSM: RUN, or STALL while extra bubbles remain.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_RUN;
            r_scnt  <= '0;
        end else if (Flush_i) begin
            r_state <= S_RUN;
            r_scnt  <= '0;
        end else if (r_state == S_STALL) begin
            r_scnt <= r_scnt - SCW'(1);
            if (r_scnt == SCW'(1)) begin
                r_state <= S_RUN;
            end
        end else if (w_hazard && (STALL_CYCLES > 1)) begin
            r_state <= S_STALL;
            r_scnt  <= STALL_INIT;
        end
    end

    // Sticky illegal flag and saturating illegal counter.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_illegal <= 1'b0;
            r_icnt    <= '0;
        end else if (w_illegal_evt) begin
            r_illegal <= 1'b1;
            if (r_icnt != {CNT_WIDTH{1'b1}}) begin
                r_icnt <= r_icnt + 1'b1;
            end
        end
    end

    assign ALUOp_o      = r_ctrl[8:7];
    assign ALUSrc_o     = r_ctrl[6];
    assign Branch_o     = r_ctrl[5];
    assign MemRead_o    = r_ctrl[4];
    assign MemWrite_o   = r_ctrl[3];
    assign RegWrite_o   = r_ctrl[2];
    assign MemtoReg_o   = r_ctrl[1];
    assign Jump_o       = r_ctrl[0];
    assign RDaddr_o     = r_rd;
    assign Stall_o      = w_stall;
    assign PCWrite_o    = rst_i && !w_stall;
    assign Illegal_o    = r_illegal;
    assign IllegalCnt_o = r_icnt;
    assign DbgState_o   = r_state;

endmodule
